// File: rtl/signal_demux.sv
// Splits a time-multiplexed sample stream into channels A and B (tagged or TDM steering).
// Optional sync-alignment checker: define SIGNAL_DEMUX_SYNC_CHECK_EN to add sync_err/sync_err_cnt.
module signal_demux #(
  parameter int DATA_W    = 10,
  parameter int BURST_LEN = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  input  logic              in_sel,
  input  logic              in_sync,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] out_a,
  output logic              out_a_valid,
  output logic [DATA_W-1:0] out_b,
  output logic              out_b_valid,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic              phase
`ifdef SIGNAL_DEMUX_SYNC_CHECK_EN
  ,
  output logic              sync_err,
  output logic [7:0]        sync_err_cnt
`endif
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(BURST_LEN - 1);

  typedef enum logic {SLOT_A, SLOT_B} slot_t;

  slot_t          slot;
  logic [BCW-1:0] burstCnt;
  logic           toB;
  logic           accA;
  logic           accB;
  logic           aligned;

  // A sync sample always lands in A, overriding the current slot.
  always_comb begin
    toB = 1'b0;
    if (!mode)
      toB = in_sel;
    else if (!in_sync)
      toB = (slot == SLOT_B);
  end

  assign accA    = in_valid & ~toB;
  assign accB    = in_valid & toB;
  assign aligned = (slot == SLOT_A) && (burstCnt == '0);
  assign phase   = (slot == SLOT_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_a       <= '0;
      out_b       <= '0;
      out_a_valid <= 1'b0;
      out_b_valid <= 1'b0;
      cnt_a       <= '0;
      cnt_b       <= '0;
      slot        <= SLOT_A;
      burstCnt    <= '0;
`ifdef SIGNAL_DEMUX_SYNC_CHECK_EN
      sync_err     <= 1'b0;
      sync_err_cnt <= '0;
`endif
    end else begin
      out_a_valid <= accA;
      out_b_valid <= accB;
      if (accA) out_a <= in_data;
      if (accB) out_b <= in_data;

      if (clr_cnt)
        cnt_a <= '0;
      else if (accA && cnt_a != '1)
        cnt_a <= cnt_a + CNT_W'(1);
      if (clr_cnt)
        cnt_b <= '0;
      else if (accB && cnt_b != '1)
        cnt_b <= cnt_b + CNT_W'(1);

      if (!mode) begin
        slot     <= SLOT_A;
        burstCnt <= '0;
      end else if (in_valid) begin
        if (in_sync) begin
          // The sync sample is already the first of a new A burst.
          if (BURST_LEN == 1) begin
            slot     <= SLOT_B;
            burstCnt <= '0;
          end else begin
            slot     <= SLOT_A;
            burstCnt <= BCW'(1);
          end
        end else if (burstCnt == LAST) begin
          slot     <= (slot == SLOT_A) ? SLOT_B : SLOT_A;
          burstCnt <= '0;
        end else begin
          burstCnt <= burstCnt + BCW'(1);
        end
      end

`ifdef SIGNAL_DEMUX_SYNC_CHECK_EN
      sync_err <= mode & in_valid & in_sync & ~aligned;
      if (clr_cnt)
        sync_err_cnt <= '0;
      else if (mode && in_valid && in_sync && !aligned && sync_err_cnt != '1)
        sync_err_cnt <= sync_err_cnt + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_signal_demux.sv
// Randomized plus directed bench for signal_demux; two instances (BURST_LEN 1 and 2, CNT_W 4)
// are checked against a position-in-frame reference model.
module tb_signal_demux;

  localparam int DW = 10;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          mode;
  logic          inValid;
  logic          inSel;
  logic          inSync;
  logic [DW-1:0] inData;
  logic          clrCnt;

  logic [DW-1:0] oA[2];
  logic [DW-1:0] oB[2];
  logic          vA[2];
  logic          vB[2];
  logic [CW-1:0] cA[2];
  logic [CW-1:0] cB[2];
  logic          ph[2];

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the A/B frame, counted in samples.
  int            bl[2] = '{1, 2};
  int            pos[2];
  logic [DW-1:0] eA[2];
  logic [DW-1:0] eB[2];
  logic          evA[2];
  logic          evB[2];
  int            ecA[2];
  int            ecB[2];

  signal_demux #(.DATA_W(DW), .BURST_LEN(1), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(inValid), .in_sel(inSel),
    .in_sync(inSync), .in_data(inData), .clr_cnt(clrCnt),
    .out_a(oA[0]), .out_a_valid(vA[0]), .out_b(oB[0]), .out_b_valid(vB[0]),
    .cnt_a(cA[0]), .cnt_b(cB[0]), .phase(ph[0]));

  signal_demux #(.DATA_W(DW), .BURST_LEN(2), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(inValid), .in_sel(inSel),
    .in_sync(inSync), .in_data(inData), .clr_cnt(clrCnt),
    .out_a(oA[1]), .out_a_valid(vA[1]), .out_b(oB[1]), .out_b_valid(vB[1]),
    .cnt_a(cA[1]), .cnt_b(cB[1]), .phase(ph[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelStep();
    int dest;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pos[i] = 0; eA[i] = '0; eB[i] = '0; evA[i] = 0; evB[i] = 0;
        ecA[i] = 0; ecB[i] = 0;
        continue;
      end
      evA[i] = 0;
      evB[i] = 0;
      if (inValid) begin
        if (!mode) begin
          dest = inSel;
        end else begin
          if (inSync) pos[i] = 0;
          dest = (pos[i] / bl[i]) % 2;
          pos[i] = (pos[i] + 1) % (2 * bl[i]);
        end
        if (dest == 0) begin
          eA[i] = inData; evA[i] = 1;
          if (ecA[i] < (1 << CW) - 1) ecA[i]++;
        end else begin
          eB[i] = inData; evB[i] = 1;
          if (ecB[i] < (1 << CW) - 1) ecB[i]++;
        end
      end
      if (!mode) pos[i] = 0;
      if (clrCnt) begin
        ecA[i] = 0;
        ecB[i] = 0;
      end
    end
  endfunction

  task automatic checkAll();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("outA%0d", i), 16'(oA[i]), 16'(eA[i]));
      chk($sformatf("outB%0d", i), 16'(oB[i]), 16'(eB[i]));
      chk($sformatf("validA%0d", i), 16'(vA[i]), 16'(evA[i]));
      chk($sformatf("validB%0d", i), 16'(vB[i]), 16'(evB[i]));
      chk($sformatf("cntA%0d", i), 16'(cA[i]), 16'(ecA[i]));
      chk($sformatf("cntB%0d", i), 16'(cB[i]), 16'(ecB[i]));
      chk($sformatf("phase%0d", i), 16'(ph[i]), 16'((pos[i] / bl[i]) % 2));
    end
  endtask

  task automatic drive(input logic r, input logic md, input logic v, input logic sel,
                       input logic sy, input logic [DW-1:0] d, input logic clr);
    rst = r; mode = md; inValid = v; inSel = sel; inSync = sy; inData = d; clrCnt = clr;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; inValid = 1'b0; inSel = 1'b0; inSync = 1'b0;
    inData = '0; clrCnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0; eA[i] = '0; eB[i] = '0; evA[i] = 0; evB[i] = 0; ecA[i] = 0; ecB[i] = 0;
    end

    // Reset held two cycles with valid samples present
    drive(1, 0, 1, 0, 0, 10'h155, 0);
    drive(1, 1, 1, 1, 0, 10'h2AA, 0);
    chk("rstPhase", 16'(ph[1]), 16'h0);
    chk("rstCnt", 16'(cA[1]), 16'h0);

    // Tagged mode
    drive(0, 0, 1, 0, 0, 10'h001, 0);
    chk("tagA1", 16'(oA[0]), 16'h001);
    drive(0, 0, 1, 1, 0, 10'h002, 0);
    chk("tagB2", 16'(oB[0]), 16'h002);
    drive(0, 0, 1, 0, 0, 10'h3FF, 0);
    chk("tagA3", 16'(oA[0]), 16'h3FF);
    chk("tagCntA", 16'(cA[0]), 16'd2);
    chk("tagCntB", 16'(cB[0]), 16'd1);

    // TDM, sync on first sample, 8 samples
    for (int k = 1; k <= 8; k++) drive(0, 1, 1, 0, k == 1, DW'(k), 0);
    chk("tdmB2last", 16'(oB[1]), 16'd8);
    chk("tdmB2lastA", 16'(oA[1]), 16'd6);

    // Resync on 4th sample
    for (int k = 1; k <= 5; k++) drive(0, 1, 1, 0, (k == 1) || (k == 4), DW'(k), 0);
    chk("resyncB1", 16'(oB[0]), 16'd5);
    chk("resyncA1", 16'(oA[0]), 16'd4);

    // Gaps: valid 1,0,0,1; sync without valid is ignored
    drive(0, 1, 1, 0, 1, 10'h011, 0);
    drive(0, 1, 0, 0, 1, 10'h022, 0);
    drive(0, 1, 0, 0, 0, 10'h033, 0);
    drive(0, 1, 1, 0, 0, 10'h044, 0);

    // Counter saturation, then clear with simultaneous A sample
    drive(0, 0, 0, 0, 0, '0, 1);
    for (int k = 0; k < 20; k++) drive(0, 0, 1, 0, 0, DW'(k), 0);
    chk("satA", 16'(cA[0]), 16'd15);
    drive(0, 0, 1, 0, 0, 10'h123, 1);
    chk("clrA", 16'(cA[0]), 16'd0);

    // Mid-burst reset drops the sample in the reset cycle
    drive(0, 1, 1, 0, 1, 10'h0AA, 0);
    drive(1, 1, 1, 0, 0, 10'h0BB, 0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 59) == 0), (k % 97) < 70 ? 1'b1 : 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 7) == 0),
            DW'($urandom), ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
